// File: rtl/pwm_ctrl_pkg.sv
// ============================================================================
// Module  : pwm_ctrl_pkg
// Brief   : Shared types, duty-width constants and the saturating step helper
//           for the PWM duty controller and the PWM generator.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pwm_ctrl_pkg;

    localparam int PWM_DUTY_W   = 4;
    localparam int PWM_DUTY_MAX = 10;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        DEBOUNCE     = 2'd1,
        APPLY        = 2'd2,
        WAIT_RELEASE = 2'd3
    } state_t;

    typedef enum logic {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } dir_t;

    // Arithmetic is done at int width so neither direction can wrap before clamping.
    function automatic int sat_step(input int cur, input int step, input dir_t dir,
                                    input int lo, input int hi);
        int nxt;
        nxt = (dir == DIR_UP) ? (cur + step) : (cur - step);
        if (nxt > hi) nxt = hi;
        if (nxt < lo) nxt = lo;
        return nxt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pwm_btn_sync.sv
// ============================================================================
// Module  : pwm_btn_sync
// Brief   : Two-flop synchronizer bringing a raw button level into clk.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_btn_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/pwm_duty_ctrl.sv
// ============================================================================
// Module  : pwm_duty_ctrl
// Brief   : Debounced up/down duty controller; new duty is committed only on
//           a PWM period boundary. Optional auto-repeat: PWM_DUTY_AUTOREPEAT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_duty_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int DUTY_W          = PWM_DUTY_W,
    parameter int DUTY_MAX        = PWM_DUTY_MAX,
    parameter int DUTY_MIN        = 0,
    parameter int DUTY_STEP       = 1,
    parameter int DUTY_RESET      = 5,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_CYCLES   = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              increase_duty_i,
    input  logic              decrease_duty_i,
    input  logic              period_start_i,
    output logic [DUTY_W-1:0] duty_o,
    output logic              duty_load_o,
    output logic              duty_pending_o,
    output logic              at_max_o,
    output logic              at_min_o
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic              up_s, dn_s;
    state_t            state_q;
    dir_t              dir_q;
    logic [DB_W-1:0]   db_cnt_q;
    logic [DUTY_W-1:0] target_q, target_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic              load_q, pending_q;
    logic [DUTY_W-1:0] w_step_val;
    logic              w_commit, w_cap, w_oth;

    pwm_btn_sync u_sync_up (.clk(clk), .rst(rst), .async_i(increase_duty_i), .sync_o(up_s));
    pwm_btn_sync u_sync_dn (.clk(clk), .rst(rst), .async_i(decrease_duty_i), .sync_o(dn_s));

`ifdef PWM_DUTY_AUTOREPEAT_EN
    localparam int RP_W = $clog2(REPEAT_CYCLES + 1);
    logic [RP_W-1:0] rpt_cnt_q;
    logic            rpt_blk_q;
`endif

    assign w_cap = (dir_q == DIR_UP) ? up_s : dn_s;
    assign w_oth = (dir_q == DIR_UP) ? dn_s : up_s;

    // Commit samples target_q, so an APPLY landing on the same edge stays pending.
    always_comb begin
        w_step_val = DUTY_W'(sat_step(int'(target_q), DUTY_STEP, dir_q, DUTY_MIN, DUTY_MAX));
        target_d   = (state_q == APPLY) ? w_step_val : target_q;
        w_commit   = period_start_i && pending_q;
        duty_d     = w_commit ? target_q : duty_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            dir_q     <= DIR_UP;
            db_cnt_q  <= '0;
            target_q  <= DUTY_W'(DUTY_RESET);
            duty_q    <= DUTY_W'(DUTY_RESET);
            load_q    <= 1'b0;
            pending_q <= 1'b0;
`ifdef PWM_DUTY_AUTOREPEAT_EN
            rpt_cnt_q <= '0;
            rpt_blk_q <= 1'b0;
`endif
        end else begin
            target_q  <= target_d;
            duty_q    <= duty_d;
            load_q    <= w_commit;
            pending_q <= (target_d != duty_d);
            case (state_q)
                IDLE: begin
                    if (up_s ^ dn_s) begin
                        state_q  <= DEBOUNCE;
                        dir_q    <= up_s ? DIR_UP : DIR_DN;
                        db_cnt_q <= '0;
                    end
                end
                DEBOUNCE: begin
                    if (!w_cap || w_oth)
                        state_q <= IDLE;
                    else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1))
                        state_q <= APPLY;
                    else
                        db_cnt_q <= db_cnt_q + 1'b1;
                end
                APPLY: begin
                    state_q <= WAIT_RELEASE;
`ifdef PWM_DUTY_AUTOREPEAT_EN
                    rpt_cnt_q <= '0;
                    rpt_blk_q <= 1'b0;
`endif
                end
                WAIT_RELEASE: begin
                    if (!up_s && !dn_s)
                        state_q <= IDLE;
`ifdef PWM_DUTY_AUTOREPEAT_EN
                    else if (w_oth)
                        rpt_blk_q <= 1'b1;
                    else if (!rpt_blk_q) begin
                        if (rpt_cnt_q == RP_W'(REPEAT_CYCLES - 1))
                            state_q <= APPLY;
                        else
                            rpt_cnt_q <= rpt_cnt_q + 1'b1;
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign duty_o         = duty_q;
    assign duty_load_o    = load_q;
    assign duty_pending_o = pending_q;
    assign at_max_o       = (target_q == DUTY_W'(DUTY_MAX));
    assign at_min_o       = (target_q == DUTY_W'(DUTY_MIN));

endmodule

`default_nettype wire
